// File: rtl/bg_bank_ctrl.sv
// rtl/bg_bank_ctrl.sv - bank-group controller: single-port array with posted-write FIFO and read forwarding
module bg_bank_ctrl #(
  parameter int A_W      = 10,
  parameter int D_W      = 32,
  parameter int WB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [2+A_W+D_W-1:0]        BG_in,
  output logic [D_W:0]                BG_resp,
  output logic [$clog2(WB_DEPTH):0]   wb_count,
  output logic                        wb_full,
  output logic                        wb_overflow,
  output logic                        busy
);
  localparam int PW = $clog2(WB_DEPTH);
  localparam int CW = PW + 1;

  logic           wen, ren;
  logic [A_W-1:0] a;
  logic [D_W-1:0] d;
  assign {wen, ren, a, d} = BG_in;

  logic [D_W-1:0] mem     [2**A_W];
  logic [A_W-1:0] wb_addr [WB_DEPTH];
  logic [D_W-1:0] wb_data [WB_DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;

  logic           push, pop, mem_we, fwd_hit;
  logic [A_W-1:0] mem_wa;
  logic [D_W-1:0] mem_wd, fwd_data;
  logic [CW-1:0]  next_count;

  always_comb begin
    pop        = !ren && busy;
    // a write beside a read is posted; a lone write bypasses only an empty FIFO
    push       = wen && (ren ? !wb_full : busy);
    mem_we     = !ren && (busy || wen);
    mem_wa     = busy ? wb_addr[rd_ptr] : a;
    mem_wd     = busy ? wb_data[rd_ptr] : d;
    next_count = wb_count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    fwd_hit    = 1'b0;
    fwd_data   = '0;
    // walk oldest to youngest so the youngest matching entry wins
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (CW'(k) < wb_count && wb_addr[rd_ptr + PW'(k)] == a) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[rd_ptr + PW'(k)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      mem[mem_wa] <= mem_wd;
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      wb_addr[wr_ptr] <= a;
      wb_data[wr_ptr] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      wb_count    <= '0;
      wb_full     <= 1'b0;
      wb_overflow <= 1'b0;
      busy        <= 1'b0;
      BG_resp     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      wb_count <= next_count;
      wb_full  <= (next_count == CW'(WB_DEPTH));
      busy     <= (next_count != '0);
      if (ren && wen && wb_full)
        wb_overflow <= 1'b1;
      BG_resp[D_W] <= ren;
      if (ren)
        BG_resp[D_W-1:0] <= fwd_hit ? fwd_data : mem[a];
    end
  end
endmodule

// File: tb/tb_bg_bank_ctrl.sv
// tb/tb_bg_bank_ctrl.sv - scoreboard bench for bg_bank_ctrl
module tb_bg_bank_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [43:0] BG_in;
  logic [32:0] BG_resp;
  logic [2:0]  wb_count;
  logic        wb_full, wb_overflow, busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  logic [31:0] amem [logic [9:0]];
  wr_t         pend[$];
  logic [31:0] exp_q[$];
  logic        ovf_m = 1'b0;

  bg_bank_ctrl dut (
    .clk(clk), .rst(rst), .BG_in(BG_in), .BG_resp(BG_resp),
    .wb_count(wb_count), .wb_full(wb_full), .wb_overflow(wb_overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [9:0] a);
    logic [31:0] v;
    v = amem.exists(a) ? amem[a] : 32'h0;
    foreach (pend[i])
      if (pend[i].a == a) v = pend[i].d;
    return v;
  endfunction

  // One cycle of stimulus: scoreboard gets the expected read value, then the response is popped and compared
  task automatic step(input logic w, input logic r, input logic [9:0] a, input logic [31:0] d);
    wr_t         e;
    logic [31:0] ev;
    if (r) exp_q.push_back(model_read(a));
    if (r && w) begin
      if (pend.size() == 4) ovf_m = 1'b1;
      else pend.push_back('{a, d});
    end else if (!r) begin
      if (pend.size() > 0) begin
        e = pend.pop_front();
        amem[e.a] = e.d;
        if (w) pend.push_back('{a, d});
      end else if (w) begin
        amem[a] = d;
      end
    end
    BG_in = {w, r, a, d};
    @(posedge clk);
    #1;
    BG_in = '0;
    checks++;
    if (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      if (BG_resp !== {1'b1, ev}) begin
        errors++;
        $display("FAIL resp addr=%h: got %h expected %h", a, BG_resp, {1'b1, ev});
      end
    end else if (BG_resp[32] !== 1'b0) begin
      errors++;
      $display("FAIL resp_valid idle: got %b expected 0", BG_resp[32]);
    end
    checks++;
    if (wb_count !== 3'(pend.size()) || wb_full !== (pend.size() == 4) ||
        busy !== (pend.size() != 0) || wb_overflow !== ovf_m) begin
      errors++;
      $display("FAIL status: got cnt=%0d full=%b busy=%b ovf=%b expected cnt=%0d full=%b busy=%b ovf=%b",
               wb_count, wb_full, busy, wb_overflow, pend.size(), pend.size() == 4, pend.size() != 0, ovf_m);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    BG_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (BG_resp !== 33'h0 || wb_count !== 3'd0 || wb_full !== 1'b0 || wb_overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got resp=%h cnt=%0d full=%b ovf=%b busy=%b expected all zero",
               BG_resp, wb_count, wb_full, wb_overflow, busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_direct_read();
    step(1'b1, 1'b0, 10'h005, 32'hDEADBEEF);
    step(1'b0, 1'b1, 10'h005, 32'h0);
    checks++;
    if (BG_resp !== {1'b1, 32'hDEADBEEF} || wb_count !== 3'd0) begin
      errors++;
      $display("FAIL direct_read: got resp=%h cnt=%0d expected %h cnt=0", BG_resp, wb_count, {1'b1, 32'hDEADBEEF});
    end
  endtask

  task automatic test_forward();
    step(1'b1, 1'b0, 10'h010, 32'h0);
    step(1'b1, 1'b1, 10'h010, 32'h11111111);
    checks++;
    if (wb_count !== 3'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL forward_post: got cnt=%0d busy=%b expected cnt=1 busy=1", wb_count, busy);
    end
    step(1'b0, 1'b1, 10'h010, 32'h0);
    checks++;
    if (BG_resp !== {1'b1, 32'h11111111}) begin
      errors++;
      $display("FAIL forward_hit: got %h expected %h", BG_resp, {1'b1, 32'h11111111});
    end
    step(1'b0, 1'b0, 10'h000, 32'h0);
    step(1'b0, 1'b1, 10'h010, 32'h0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 10'h020 + 10'(i), 32'hA0000000 + i);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 10'h020 + 10'(i), 32'hC0DE0000 + i);
      if (i == 3) begin
        checks++;
        if (wb_full !== 1'b1) begin
          errors++;
          $display("FAIL full_after_4: got %b expected 1", wb_full);
        end
      end
    end
    repeat (5) step(1'b0, 1'b0, 10'h000, 32'h0);
    checks++;
    if (wb_overflow !== 1'b1 || wb_count !== 3'd0) begin
      errors++;
      $display("FAIL overflow_sticky: got ovf=%b cnt=%0d expected ovf=1 cnt=0", wb_overflow, wb_count);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 10'h020 + 10'(i), 32'h0);
    checks++;
    if (BG_resp !== {1'b1, 32'hA0000004}) begin
      errors++;
      $display("FAIL dropped_write: got %h expected %h", BG_resp, {1'b1, 32'hA0000004});
    end
  endtask

  task automatic test_same_cycle();
    step(1'b1, 1'b0, 10'h030, 32'h0000AAAA);
    step(1'b1, 1'b1, 10'h030, 32'h22222222);
    checks++;
    if (BG_resp !== {1'b1, 32'h0000AAAA}) begin
      errors++;
      $display("FAIL read_before_write: got %h expected %h", BG_resp, {1'b1, 32'h0000AAAA});
    end
    step(1'b0, 1'b0, 10'h000, 32'h0);
    step(1'b0, 1'b1, 10'h030, 32'h0);
  endtask

  task automatic test_write_order();
    step(1'b1, 1'b0, 10'h040, 32'h0);
    step(1'b1, 1'b1, 10'h040, 32'h1);
    step(1'b1, 1'b1, 10'h040, 32'h2);
    step(1'b1, 1'b0, 10'h040, 32'h3);
    checks++;
    if (wb_count !== 3'd2) begin
      errors++;
      $display("FAIL pop_push_occupancy: got %0d expected 2", wb_count);
    end
    step(1'b0, 1'b0, 10'h000, 32'h0);
    step(1'b0, 1'b0, 10'h000, 32'h0);
    step(1'b0, 1'b1, 10'h040, 32'h0);
    checks++;
    if (BG_resp !== {1'b1, 32'h3} || wb_count !== 3'd0) begin
      errors++;
      $display("FAIL last_write_wins: got resp=%h cnt=%0d expected %h cnt=0", BG_resp, wb_count, {1'b1, 32'h3});
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'h050 + 10'(i), 32'h5A000000 + i);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'h050 + 10'(i), 32'hF0000000 + i);
    rst   = 1'b1;
    BG_in = {1'b0, 1'b1, 10'h050, 32'h0};
    pend.delete();
    exp_q.delete();
    ovf_m = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (wb_count !== 3'd0 || busy !== 1'b0 || wb_overflow !== 1'b0 || BG_resp[32] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got cnt=%0d busy=%b ovf=%b valid=%b expected zeros",
               wb_count, busy, wb_overflow, BG_resp[32]);
    end
    step(1'b0, 1'b0, 10'h000, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 10'h050 + 10'(i), 32'h0);
    checks++;
    if (BG_resp !== {1'b1, 32'h5A000002}) begin
      errors++;
      $display("FAIL discarded_posts: got %h expected %h", BG_resp, {1'b1, 32'h5A000002});
    end
  endtask

  initial begin
    rst   = 1'b1;
    BG_in = '0;
    test_reset();
    test_direct_read();
    test_forward();
    test_overflow();
    test_same_cycle();
    test_write_order();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
